// File: rtl/alu_pipe.sv
// Fully pipelined WIDTH-bit ALU, 8 opcodes, fixed STAGES-cycle latency.
// All stages share one stall (out_valid && !out_ready), so results retire in order.
module alu_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opsel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned HALF = WIDTH / 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_MUL = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_res [STAGES];
  logic              r_mul0;
  logic [WIDTH-1:0]  r_plo;
  logic [WIDTH-1:0]  r_phi;

  logic              w_stall;
  logic              w_adv;
  logic              w_take;
  logic [WIDTH-1:0]  w_plo;
  logic [WIDTH-1:0]  w_phi;
  logic [WIDTH-1:0]  w_msum;
  logic [WIDTH-1:0]  w_alu;
  logic [WIDTH-1:0]  w_nxt [STAGES];
  logic [STAGES-1:0] w_en;

  assign w_stall   = r_valid[STAGES-1] && !out_ready;
  assign w_adv     = !w_stall;
  assign w_take    = w_adv && in_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[STAGES-1];
  assign out       = r_res[STAGES-1];

  // Product split on B halves; the halves are summed one stage later when STAGES > 1.
  assign w_plo  = in0 * WIDTH'(in1[HALF-1:0]);
  assign w_phi  = in0 * WIDTH'(in1[WIDTH-1:HALF]);
  assign w_msum = r_plo + (r_phi << HALF);

  // Stage-1 result for every op except a split multiply.
  always_comb begin
    w_alu = '0;
    case (opsel)
      OP_ADD: w_alu = in0 + in1;
      OP_MUL: w_alu = (STAGES == 1) ? (w_plo + (w_phi << HALF)) : '0;
      OP_SUB: w_alu = in0 - in1;
      OP_AND: w_alu = in0 & in1;
      OP_OR:  w_alu = in0 | in1;
      OP_XOR: w_alu = in0 ^ in1;
      OP_SHL: w_alu = in0 << in1[SHW-1:0];
      OP_SHR: w_alu = in0 >> in1[SHW-1:0];
      default: w_alu = '0;
    endcase
  end

  // Per-stage next data and load enables; data registers load only under a valid beat.
  always_comb begin
    w_nxt[0] = w_alu;
    w_en     = '0;
    w_en[0]  = w_take;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_nxt[k] = (k == 1 && r_mul0) ? w_msum : r_res[k-1];
      w_en[k]  = w_adv && r_valid[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_mul0  <= 1'b0;
      r_plo   <= '0;
      r_phi   <= '0;
      for (int unsigned k = 0; k < STAGES; k++) r_res[k] <= '0;
    end else begin
      if (w_adv) begin
        r_valid[0] <= in_valid;
        for (int unsigned k = 1; k < STAGES; k++) r_valid[k] <= r_valid[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (w_en[k]) r_res[k] <= w_nxt[k];
      end
      if (w_take) begin
        r_mul0 <= (opsel == OP_MUL);
        r_plo  <= w_plo;
        r_phi  <= w_phi;
      end
    end
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, fully pipelined successor to the 32-bit two-operation ALU.
- Generalises datapath width and opcode set (8 ops).
- Adds a pipelined multiplier with configurable depth and a valid/ready handshake with backpressure.
- Sits between the operand-fetch stage and writeback; all ops share one fixed latency so results retire in order.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 2, power of two).
- STAGES, 3, pipeline depth = fixed latency for every op (>= 1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  pipe can accept a beat this cycle.
- opsel  input  3  operation select (see Behaviour).
- in0  input  WIDTH  operand A.
- in1  input  WIDTH  operand B.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result this cycle.
- out  output  WIDTH  result.

Behaviour:
- Reset: one clock; synchronous and active-high.
  - A rising edge with reset=1 clears every stage valid bit.
  - After reset: out_valid=0, out=0, in_ready=1.
  - Reset mid-operation discards all in-flight beats; no result for them ever appears.
  - Reset has priority over any simultaneous handshake.
- Opcodes, all results truncated to WIDTH (mod 2^WIDTH):
  - 0 add: A+B.
  - 1 mul: low WIDTH bits of A*B.
  - 2 sub: A-B, two's complement.
  - 3 and.
  - 4 or.
  - 5 xor.
  - 6 shl: A << B[log2(WIDTH)-1:0].
  - 7 shr: logical shift, A >> B[log2(WIDTH)-1:0].
- Upper bits of B are ignored for shifts.
- Accept: a beat is accepted on an edge where in_valid && in_ready.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (visible STAGES cycles after the accept cycle), provided no stalls.
- Multiplier: split across STAGES (partial products may be registered at any stage boundary). Non-mul ops are computed in stage 1 and carried through matching registers.
- Ordering: strict in-order; mixed opcodes never reorder.
- Handshake: one global stall signal, stall = out_valid && !out_ready.
  - When stall=1, all stages hold (data and valid) and in_ready=0.
  - When stall=0, the pipe advances and in_ready=1.
  - in_ready must not depend combinationally on in_valid.
- Bubbles: in_valid=0 inserts a bubble that travels down the pipe; out_valid=0 in the corresponding cycle. out holds its last value when out_valid=0 (no requirement to zero it).
- Throughput: one beat per cycle when out_ready is held high.
- While in_ready=0, in_valid/opsel/in0/in1 are don't-care and X on them must not propagate into state. Valid bits gate all register enables.
- Output hold: out and out_valid are stable while stalled.
- No overflow/carry flags; wrap-around is silent.

Test Plan:
- Reset then in0=2, in1=4, opsel=0, in_valid one cycle, out_ready=1 -> out_valid pulses once, STAGES cycles later, with out=6.
- Back-to-back stream of four beats, in0=2, in1=4, ops mul/sub/xor/shl -> four consecutive out_valid cycles with out=8, 0xFFFFFFFE, 6, 0x20 in order.
- Wrap and shift masking:
  - in0=0xFFFFFFFF, in1=2, add -> 1.
  - mul -> 0xFFFFFFFE.
  - shr with in1=33 -> 0x7FFFFFFF (shift by 1).
- Backpressure: stream three adds (1+1, 2+2, 3+3); drop out_ready for 4 cycles when the first result appears -> in_ready=0 and out=2 held throughout; on release, 2, 4, 6 retire with no loss or duplication.
- Reset mid-flight: issue two muls, assert reset one cycle later -> out_valid stays 0 for the following STAGES+2 cycles; a fresh add 2+4 then returns 6.
- Bubbles and X inputs: alternate in_valid 1/0 with in0=in1='x during invalid cycles -> out_valid alternates, valid results correct, no X on out when out_valid=1.
